tick_timer_ctrl: RTL and testbench

- Drives the increment side of the 0-to-100 counter interface and consumes its timeout strobe. It is the producer/consumer at the other end of that counter's interface.
- A prescaler generates one-cycle `incre_out` strobes every `TICK_DIV` clocks.
- Each returned `timeout_in` pulse decrements a loaded countdown value. When the value reaches zero, a one-cycle `done` pulse is issued.
- Sits between the game/control FSM (`start`, `pause`, `load_val`, `done`) and a downstream counter instance (`incre_out`, `cnt_rst_n`, `timeout_in`).

---
 rtl/tick_timer_ctrl.sv | 85 ++++++++
 tb/tb_tick_timer_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: prescaled increment-strobe driver and timeout countdown for a downstream counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request to load load_val and begin counting down
//   pause           level; freezes the prescaler while running
//   load_val        countdown start value in timeout units
//   timeout_in      one-cycle strobe returned by the downstream counter
//   incre_out       one-cycle increment strobe every TICK_DIV running cycles
//   cnt_rst_n       active-low reset to the downstream counter
//   remaining       current countdown value
//   busy, done      activity level and one-cycle completion pulse
module tick_timer_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int PRE_W    = 19,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] load_val,
    input  logic             timeout_in,
    output logic             incre_out,
    output logic             cnt_rst_n,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, RUN = 3'd2, PAUSED = 3'd3, DONE = 3'd4;
    logic [2:0]       state, nxt_state;
    logic [PRE_W-1:0] pre, nxt_pre;
    logic [CNT_W-1:0] nxt_rem;
    logic             tick;
    logic             active, wrap;
    assign active = (state == RUN) || (state == PAUSED);
    assign wrap   = pre == PRE_W'(TICK_DIV - 1);
    always_comb begin
        nxt_state = state;
        nxt_pre   = pre;
        nxt_rem   = remaining;
        tick      = 1'b0;
        if (start && state != ARM) begin
            nxt_rem   = load_val;
            nxt_pre   = '0;
            nxt_state = (load_val == '0) ? DONE : ARM;
        end else if (state == ARM) begin
            nxt_state = RUN;
        end else if (state == DONE) begin
            nxt_state = IDLE;
        end else if (active) begin
            if (timeout_in && remaining <= CNT_W'(1)) begin
                nxt_rem   = '0;
                nxt_state = DONE;
            end else begin
                if (timeout_in) nxt_rem = remaining - 1'b1;
                // a timeout outranks pause, so RUN keeps ticking on that cycle
                if (state == RUN && (timeout_in || !pause)) begin
                    tick    = wrap;
                    nxt_pre = wrap ? '0 : pre + 1'b1;
                end else begin
                    nxt_state = pause ? PAUSED : RUN;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre       <= '0;
            remaining <= '0;
            incre_out <= 1'b0;
            cnt_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            pre       <= nxt_pre;
            remaining <= nxt_rem;
            incre_out <= tick;
            cnt_rst_n <= (nxt_state == RUN) || (nxt_state == PAUSED);
            busy      <= (nxt_state == ARM) || (nxt_state == RUN) || (nxt_state == PAUSED);
            done      <= nxt_state == DONE;
        end
    end
endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb_tick_timer_ctrl: directed stimulus with an event scoreboard for tick_timer_ctrl.
module tb_tick_timer_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, pause, timeout_in;
    logic [7:0] load_val;
    logic       incre_out, cnt_rst_n, busy, done;
    logic [7:0] remaining;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int b;
    typedef struct {
        bit         kind;
        int         cyc;
        logic [7:0] rem;
    } ev_t;
    ev_t q[$];

    tick_timer_ctrl #(.TICK_DIV(4), .PRE_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .load_val(load_val),
        .timeout_in(timeout_in), .incre_out(incre_out), .cnt_rst_n(cnt_rst_n),
        .remaining(remaining), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = incre_out strobe, kind 1 = done pulse
    task automatic push(input bit kind, input int c, input logic [7:0] rem);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rem  = rem;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (incre_out || done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: incre=%0b done=%0b at cycle %0d, none expected", incre_out, done, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.kind != done || e.cyc != cyc || e.rem != remaining) begin
                    failures++;
                    $display("FAIL event: got done=%0b cycle=%0d rem=%0d expected done=%0b cycle=%0d rem=%0d",
                             done, cyc, remaining, e.kind, e.cyc, e.rem);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; load_val = '0; timeout_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_cnt_rst_n", cnt_rst_n, 0);
        chk("reset_remaining", remaining, 0);
        chk("reset_incre", incre_out, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        // basic countdown of 3 with strobes every 4 running cycles
        b = cyc + 2;
        at(b); start = 1'b1; load_val = 8'd3;
        push(0, b + 6, 3); push(0, b + 10, 3); push(0, b + 14, 1); push(1, b + 16, 0);
        at(b + 1); start = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_cnt_rst_n", cnt_rst_n, 0);
        chk("arm_remaining", remaining, 3);
        at(b + 2); chk("run_cnt_rst_n", cnt_rst_n, 1);
        at(b + 11); timeout_in = 1'b1;
        at(b + 12); timeout_in = 1'b0; chk("dec_to_2", remaining, 2);
        at(b + 13); timeout_in = 1'b1;
        at(b + 14); timeout_in = 1'b0; chk("dec_to_1", remaining, 1);
        at(b + 15); timeout_in = 1'b1;
        at(b + 16); timeout_in = 1'b0;
        chk("done_remaining", remaining, 0);
        chk("done_busy", busy, 0);
        chk("done_cnt_rst_n", cnt_rst_n, 0);
        at(b + 17); chk("idle_done_low", done, 0); chk("idle_busy", busy, 0);
        // pause at prescaler 2 for 10 cycles, with a late timeout while paused
        b = cyc + 10;
        at(b); start = 1'b1; load_val = 8'd4;
        push(0, b + 17, 3); push(0, b + 21, 3); push(0, b + 25, 1); push(1, b + 27, 0);
        at(b + 1); start = 1'b0;
        at(b + 4); pause = 1'b1;
        at(b + 5); chk("paused_cnt_rst_n", cnt_rst_n, 1); chk("paused_busy", busy, 1);
        at(b + 8); timeout_in = 1'b1;
        at(b + 9); timeout_in = 1'b0; chk("paused_dec", remaining, 3);
        at(b + 14); pause = 1'b0;
        at(b + 22); timeout_in = 1'b1;
        at(b + 23); timeout_in = 1'b0;
        at(b + 24); timeout_in = 1'b1;
        at(b + 25); timeout_in = 1'b0;
        at(b + 26); timeout_in = 1'b1;
        at(b + 27); timeout_in = 1'b0;
        at(b + 28); chk("pause_run_idle_busy", busy, 0);
        // zero load goes straight to DONE
        b = cyc + 2;
        at(b); start = 1'b1; load_val = 8'd0;
        push(1, b + 1, 0);
        at(b + 1); start = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_cnt_rst_n", cnt_rst_n, 0);
        at(b + 2); chk("zero_done_low", done, 0);
        // restart with coincident timeout drops the timeout
        b = cyc + 2;
        at(b); start = 1'b1; load_val = 8'd5;
        push(0, b + 6, 5); push(0, b + 13, 9);
        at(b + 1); start = 1'b0;
        at(b + 7); chk("before_restart_rem", remaining, 5);
        start = 1'b1; load_val = 8'd9; timeout_in = 1'b1;
        at(b + 8); start = 1'b0; timeout_in = 1'b0;
        chk("restart_rem", remaining, 9);
        chk("restart_cnt_rst_n", cnt_rst_n, 0);
        chk("restart_busy", busy, 1);
        at(b + 9); chk("restart_run", cnt_rst_n, 1);
        // asynchronous reset between edges mid-RUN
        at(b + 15); #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_cnt_rst_n", cnt_rst_n, 0);
        chk("async_remaining", remaining, 0);
        chk("async_incre", incre_out, 0);
        at(b + 17); rst = 1'b0;
        at(b + 18); timeout_in = 1'b1;
        at(b + 19); timeout_in = 1'b0;
        at(b + 21); timeout_in = 1'b1;
        at(b + 22); timeout_in = 1'b0;
        at(b + 30);
        chk("post_reset_remaining", remaining, 0);
        chk("post_reset_busy", busy, 0);
        chk("events_consumed", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
